// File: rtl/wsp_pkg.sv
// Shared types and constants for the s349 wrapper serial port driver:
// FSM state encoding, WIR opcodes and default shift geometry.
package wsp_pkg;

  localparam int WIR_W       = 3;
  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;

  localparam logic [WIR_W-1:0] WS_BYPASS  = 3'b000;
  localparam logic [WIR_W-1:0] WS_EXTEST  = 3'b001;
  localparam logic [WIR_W-1:0] WS_INTEST  = 3'b010;
  localparam logic [WIR_W-1:0] WP_PRELOAD = 3'b011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/wsp_wir_driver_if.sv
// Request/response handshake plus WSP pins between controller, driver and wrapper.
// Optional expect/mask compare ports appear when WSP_EXPECT_CHECK_EN is defined.
interface wsp_wir_driver_if #(
  parameter int MAX_LEN = wsp_pkg::MAX_LEN_DEF,
  parameter int LEN_W   = wsp_pkg::LEN_W_DEF
);
  logic               req_valid;
  logic               req_ready;
  logic               req_sel_wir;
  logic [LEN_W-1:0]   req_len;
  logic [MAX_LEN-1:0] req_data;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  logic               SelectWIR;
  logic               CaptureWR;
  logic               ShiftWR;
  logic               UpdateWR;
  logic               WSI;
  logic               WSO;
`ifdef WSP_EXPECT_CHECK_EN
  logic [MAX_LEN-1:0] req_expect;
  logic [MAX_LEN-1:0] req_mask;
  logic               rsp_mismatch;
`endif

  // Controller and wrapper side: issues requests, returns WSO.
  modport master (
`ifdef WSP_EXPECT_CHECK_EN
    output req_expect, req_mask,
    input  rsp_mismatch,
`endif
    output req_valid, req_sel_wir, req_len, req_data, rsp_ready, WSO,
    input  req_ready, rsp_valid, rsp_data,
    input  SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI
  );

  // Driver side.
  modport slave (
`ifdef WSP_EXPECT_CHECK_EN
    input  req_expect, req_mask,
    output rsp_mismatch,
`endif
    input  req_valid, req_sel_wir, req_len, req_data, rsp_ready, WSO,
    output req_ready, rsp_valid, rsp_data,
    output SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI
  );

endinterface

// File: rtl/wsp_serializer.sv
// Shift datapath of the WSP driver: data shift register, bit counter and the
// WSO capture register. Sequencing is owned by the FSM in wsp_wir_driver.
module wsp_serializer #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [LEN_W-1:0]   len_in,
  input  logic [MAX_LEN-1:0] data_in,
  input  logic               wso,
  output logic               next_bit,
  output logic               done,
  output logic               len_zero,
  output logic [MAX_LEN-1:0] cap
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] sr_q;
  logic [MAX_LEN-1:0] cap_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   len_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values;
  // these data registers are small, so they are reset too and rsp_data reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      cap_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (load) begin
      sr_q  <= data_in;
      cap_q <= '0;
      cnt_q <= '0;
      len_q <= (len_in > LEN_MAX) ? LEN_MAX : len_in;
    end else if (shift) begin
      sr_q  <= sr_q >> 1;
      cnt_q <= cnt_q + 1'b1;
      cap_q <= cap_q | (MAX_LEN'(wso) << cnt_q);
    end
  end

  // While shifting, the bit for the following cycle is already at sr_q[1].
  assign next_bit = shift ? sr_q[1] : sr_q[0];
  assign done     = ((cnt_q + 1'b1) == len_q);
  assign len_zero = (len_q == '0);
  assign cap      = cap_q;

endmodule

// File: rtl/wsp_wir_driver.sv
// WSP initiator for the s349 wrapper: sequences Capture/Shift/Update around a
// parallel load request. Optional expect/mask compare: WSP_EXPECT_CHECK_EN.
module wsp_wir_driver
  import wsp_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic             WRCK,
  input  logic             WRST,
  wsp_wir_driver_if.slave  bus
);

  state_t state_q, state_nx;

  logic sel_q;
  logic select_q, capture_q, shift_q, update_q, wsi_q;
  logic rsp_valid_q, req_ready_q;
  logic accept, shifting;
  logic ser_next_bit, ser_done, ser_len_zero;
  logic [MAX_LEN-1:0] ser_cap;

  assign accept   = (state_q == ST_IDLE) && bus.req_valid;
  assign shifting = (state_q == ST_SHIFT);

  wsp_serializer #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_ser (
    .clk      (WRCK),
    .rst      (WRST),
    .load     (accept),
    .shift    (shifting),
    .len_in   (bus.req_len),
    .data_in  (bus.req_data),
    .wso      (bus.WSO),
    .next_bit (ser_next_bit),
    .done     (ser_done),
    .len_zero (ser_len_zero),
    .cap      (ser_cap)
  );

  // NOTE: state_nx gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:    if (bus.req_valid) state_nx = ST_CAPTURE;
      ST_CAPTURE: state_nx = ser_len_zero ? ST_UPDATE : ST_SHIFT;
      ST_SHIFT:   if (ser_done) state_nx = ST_UPDATE;
      ST_UPDATE:  state_nx = ST_RESP;
      ST_RESP:    if (bus.rsp_ready) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // Pins are decoded from the next state so every WSP output comes straight from a flop.
  always_ff @(posedge WRCK) begin
    if (WRST) begin
      state_q     <= ST_IDLE;
      sel_q       <= 1'b0;
      select_q    <= 1'b0;
      capture_q   <= 1'b0;
      shift_q     <= 1'b0;
      update_q    <= 1'b0;
      wsi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_nx;
      if (accept) sel_q <= bus.req_sel_wir;
      select_q    <= (state_nx inside {ST_CAPTURE, ST_SHIFT, ST_UPDATE})
                     && (accept ? bus.req_sel_wir : sel_q);
      capture_q   <= (state_nx == ST_CAPTURE);
      shift_q     <= (state_nx == ST_SHIFT);
      update_q    <= (state_nx == ST_UPDATE);
      wsi_q       <= (state_nx == ST_SHIFT) && ser_next_bit;
      rsp_valid_q <= (state_nx == ST_RESP);
      req_ready_q <= (state_nx == ST_IDLE);
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = ser_cap;
  assign bus.SelectWIR = select_q;
  assign bus.CaptureWR = capture_q;
  assign bus.ShiftWR   = shift_q;
  assign bus.UpdateWR  = update_q;
  assign bus.WSI       = wsi_q;

`ifdef WSP_EXPECT_CHECK_EN
  logic [MAX_LEN-1:0] expect_q;
  logic [MAX_LEN-1:0] mask_q;

  always_ff @(posedge WRCK) begin
    if (WRST) begin
      expect_q <= '0;
      mask_q   <= '0;
    end else if (accept) begin
      expect_q <= bus.req_expect;
      mask_q   <= bus.req_mask;
    end
  end

  assign bus.rsp_mismatch = rsp_valid_q && (|((ser_cap ^ expect_q) & mask_q));
`endif

endmodule

// File: tb/tb_wsp_wir_driver.sv
// Self-checking bench for wsp_wir_driver: table vectors, reset corner cases and
// randomized loads against a timeline model of the WSP sequence.
module tb_wsp_wir_driver;
  import wsp_pkg::*;

  localparam int ML = 8;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wsp_wir_driver_if #(.MAX_LEN(ML), .LEN_W(LW)) bus ();

  wsp_wir_driver #(.MAX_LEN(ML), .LEN_W(LW)) dut (
    .WRCK (clk),
    .WRST (rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, rsp_valid, req_ready}
  logic [6:0] pins;
  assign pins = {bus.SelectWIR, bus.CaptureWR, bus.ShiftWR, bus.UpdateWR,
                 bus.WSI, bus.rsp_valid, bus.req_ready};

  localparam logic [6:0] PINS_IDLE = 7'b0000001;
  localparam logic [6:0] PINS_RESP = 7'b0000010;

  typedef struct {
    logic       sel;
    logic [3:0] len;
    logic [7:0] data;
    logic [7:0] wso;
    int         delay;
    bit         hold;
    logic [7:0] expv;
    logic [7:0] mask;
    logic [7:0] exp_rsp;
    logic       exp_mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response the wrapper should produce: WSO bits of the first min(len,8) shift cycles.
  function automatic logic [7:0] model_rsp(input logic [3:0] len, input logic [7:0] wso);
    int L;
    logic [7:0] r;
    L = (len > 4'd8) ? 8 : int'(len);
    r = '0;
    for (int i = 0; i < L; i++) r[i] = wso[i];
    return r;
  endfunction

  // Expected pins in the k-th cycle after the acceptance edge (k = 1 is CAPTURE).
  function automatic logic [6:0] model_pins(input int k, input int L, input logic sel,
                                           input logic [7:0] data);
    if (k == 1)
      return {sel, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    else if (k <= L + 1)
      return {sel, 1'b0, 1'b1, 1'b0, data[k-2], 1'b0, 1'b0};
    else if (k == L + 2)
      return {sel, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    else
      return PINS_RESP;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int  L;
    bit  ok;
    L  = (v.len > 4'd8) ? 8 : int'(v.len);
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_ready_wait"}, 32'(ok), 32'd1);
    if (!ok) return;

    bus.req_valid   = 1'b1;
    bus.req_sel_wir = v.sel;
    bus.req_len     = v.len;
    bus.req_data    = v.data;
`ifdef WSP_EXPECT_CHECK_EN
    bus.req_expect  = v.expv;
    bus.req_mask    = v.mask;
`endif
    tick();
    // Request fields are scrambled after acceptance; the driver must have latched them.
    bus.req_valid   = 1'b0;
    bus.req_sel_wir = 1'($urandom);
    bus.req_len     = 4'($urandom);
    bus.req_data    = 8'($urandom);
`ifdef WSP_EXPECT_CHECK_EN
    bus.req_expect  = 8'($urandom);
    bus.req_mask    = 8'($urandom);
`endif

    for (int k = 1; k <= L + 2; k++) begin
      check($sformatf("%s_pins_k%0d", tag, k), 32'(pins), 32'(model_pins(k, L, v.sel, v.data)));
      bus.WSO       = (k >= 2 && k <= L + 1) ? v.wso[k-2] : 1'($urandom);
      bus.rsp_ready = 1'($urandom);
      tick();
    end

    bus.WSO = 1'b0;
    for (int d = 0; d <= v.delay; d++) begin
      check($sformatf("%s_resp_pins_%0d", tag, d), 32'(pins), 32'(PINS_RESP));
      check($sformatf("%s_rsp_data_%0d", tag, d), 32'(bus.rsp_data), 32'(v.exp_rsp));
`ifdef WSP_EXPECT_CHECK_EN
      check($sformatf("%s_mismatch_%0d", tag, d), 32'(bus.rsp_mismatch), 32'(v.exp_mis));
`endif
      if (v.hold) begin
        bus.req_valid = 1'b1;
        bus.req_len   = 4'd3;
      end
      bus.rsp_ready = (d == v.delay);
      tick();
    end
    bus.rsp_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(pins), 32'(PINS_IDLE));
    bus.req_valid = 1'b0;
    if (v.hold) begin
      tick();
      check({tag, "_pending_not_taken"}, 32'(pins), 32'(PINS_IDLE));
    end
  endtask

  vec_t vecs[7];
  vec_t rv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'd3,  8'b0000_0110, 8'b0000_0101, 0, 1'b0, 8'b101, 8'b111, 8'h05, 1'b0};
    vecs[1] = '{1'b0, 4'd0,  8'hFF,        8'hFF,        1, 1'b0, 8'h00,  8'hFF,  8'h00, 1'b0};
    vecs[2] = '{1'b0, 4'd12, 8'hA5,        8'h3C,        0, 1'b0, 8'h3C,  8'hFF,  8'h3C, 1'b0};
    vecs[3] = '{1'b1, 4'd3,  8'(WP_PRELOAD), 8'b0000_0111, 5, 1'b1, 8'b101, 8'b111, 8'h07, 1'b1};
    vecs[4] = '{1'b0, 4'd8,  8'h5A,        8'hC3,        2, 1'b0, 8'hC3,  8'h0F,  8'hC3, 1'b0};
    vecs[5] = '{1'b1, 4'd1,  8'h01,        8'hFE,        0, 1'b0, 8'h01,  8'h01,  8'h00, 1'b1};
    vecs[6] = '{1'b0, 4'd9,  8'h81,        8'h80,        1, 1'b0, 8'h80,  8'hFF,  8'h80, 1'b0};

    // Reset with a request present: reset must win.
    rst             = 1'b1;
    bus.req_valid   = 1'b1;
    bus.req_sel_wir = 1'b1;
    bus.req_len     = 4'd3;
    bus.req_data    = 8'h06;
    bus.rsp_ready   = 1'b0;
    bus.WSO         = 1'b0;
`ifdef WSP_EXPECT_CHECK_EN
    bus.req_expect  = '0;
    bus.req_mask    = '0;
`endif
    for (int c = 0; c < 2; c++) begin
      tick();
      check($sformatf("reset_pins_%0d", c), 32'(pins), 32'(PINS_IDLE));
      check($sformatf("reset_rsp_data_%0d", c), 32'(bus.rsp_data), 32'd0);
`ifdef WSP_EXPECT_CHECK_EN
      check($sformatf("reset_mismatch_%0d", c), 32'(bus.rsp_mismatch), 32'd0);
`endif
    end
    bus.req_valid = 1'b0;
    rst           = 1'b0;
    tick();
    check("post_reset_idle", 32'(pins), 32'(PINS_IDLE));

    for (int i = 0; i < 7; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset during shift cycle 1 of an 8-bit load discards the transfer.
    bus.req_valid   = 1'b1;
    bus.req_sel_wir = 1'b1;
    bus.req_len     = 4'd8;
    bus.req_data    = 8'hFF;
    tick();
    bus.req_valid = 1'b0;
    check("midrst_capture", 32'(pins), 32'(model_pins(1, 8, 1'b1, 8'hFF)));
    tick();
    tick();
    check("midrst_shift1", 32'(pins), 32'(model_pins(3, 8, 1'b1, 8'hFF)));
    rst = 1'b1;
    tick();
    check("midrst_forced_idle", 32'(pins), 32'(PINS_IDLE));
    rst = 1'b0;
    rv = '{1'b0, 4'd2, 8'b10, 8'b01, 0, 1'b0, 8'h00, 8'h00, 8'h01, 1'b0};
    run_txn(rv, "after_rst");

    // Randomized loads, expectations from the timeline/response model.
    for (int n = 0; n < 25; n++) begin
      rv.sel     = 1'($urandom);
      rv.len     = 4'($urandom_range(0, 15));
      rv.data    = 8'($urandom);
      rv.wso     = 8'($urandom);
      rv.delay   = int'($urandom_range(0, 3));
      rv.hold    = 1'($urandom);
      rv.expv    = 8'($urandom);
      rv.mask    = 8'($urandom);
      rv.exp_rsp = model_rsp(rv.len, rv.wso);
      rv.exp_mis = |((rv.exp_rsp ^ rv.expv) & rv.mask);
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
